// File: rtl/bec_la_host_sequencer.sv
// ----------------------------------------------------------------------------
// bec_la_host_sequencer
//   Host (initiator) end of the BEC operand loader's logic-analyzer link.
//   Seven 163-bit operands (a,b,c,d,e,f,h) are written locally. On start they
//   are sent as 14 tagged LA words, and each word waits for its own ack. The
//   sequencer then issues the process command, walks the four read selectors
//   and captures four 82-bit result words.
//
//   Optional build macro: BEC_SEQ_TIMEOUT_EN
//     defined   : every ack/valid wait is bounded by TIMEOUT sampled cycles.
//                 On expiry the sequencer goes through ERR and sets
//                 error/err_chunk.
//     undefined : waits are unbounded; error and err_chunk are tied low.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   op_we/op_sel/op_wdata   operand write port (ignored while busy, sel 7 ignored)
//   start          begin a transaction (only sampled in IDLE)
//   busy/done      transaction in flight / one-cycle completion pulse
//   error/err_chunk sticky timeout flag and the chunk/read index that expired
//   rd_idx/rd_data combinational read of captured result words
//   la_out         to loader la_data_in
//   la_oenb_out    to loader la_oenb
//   la_in          from loader la_data_out
// ----------------------------------------------------------------------------
// state | meaning
// IDLE  | link quiet, waiting for start
// ARM   | load command driven, no chunk, SETTLE cycles
// SEND  | chunk k driven; after SETTLE cycles wait for its ack
// PROC  | process command driven for SETTLE+1 cycles
// READ  | read selector i driven; after SETTLE cycles wait for valid header
// DONE  | one-cycle completion pulse
// ERR   | one-cycle timeout exit (timeout build only)
// ----------------------------------------------------------------------------
module bec_la_host_sequencer #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_we,
  input  logic [2:0]   op_sel,
  input  logic [162:0] op_wdata,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [3:0]   err_chunk,
  input  logic [1:0]   rd_idx,
  output logic [81:0]  rd_data,
  output logic [127:0] la_out,
  output logic [127:0] la_oenb_out,
  input  logic [127:0] la_in
);

  localparam int CW = $clog2(SETTLE + 1) + 1;
  localparam logic [CW-1:0] C_SETTLE    = CW'(SETTLE);
  localparam logic [CW-1:0] C_SETTLE_M1 = CW'(SETTLE - 1);
  localparam logic [15:0]   CMD_LOAD    = 16'hAB40;
  localparam logic [15:0]   CMD_PROC    = 16'hAB41;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SEND, S_PROC, S_READ, S_DONE, S_ERR
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [3:0]     r_k;
  logic [3:0]     w_k_nxt;
  logic [1:0]     r_i;
  logic [1:0]     w_i_nxt;
  logic [162:0]   r_ops [7];
  logic [81:0]    r_res [4];

  logic           w_settled;
  logic           w_ack;
  logic           w_valid;
  logic           w_tmo_hit;
  logic           w_restart;
  logic           w_capture;
  logic           w_busy;
  logic           w_done;
  logic           w_chunk_en;
  logic [15:0]    w_cmd;
  logic [3:0]     w_err_chunk_nxt;
  logic [2:0]     w_op_idx;
  logic [162:0]   w_op;
  logic [13:0]    w_tag;
  logic [81:0]    w_payload;
  logic [127:0]   w_la;

  // Settle timer: a down-counter, sampling is allowed once it reaches zero.
  assign w_settled = (r_cnt == '0);
  // Only chunk k's own ack code matches, so a lingering ack of k-1 is ignored.
  assign w_ack     = (la_in[95:90] == (6'h10 + {2'b00, r_k}));
  assign w_valid   = (la_in[127:126] == 2'b11);
  assign w_err_chunk_nxt = (r_state == S_SEND) ? r_k : (4'hC + {2'b00, r_i});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? (r_cnt - 1'b1) : r_cnt;
    w_k_nxt     = r_k;
    w_i_nxt     = r_i;
    w_capture   = 1'b0;
    w_restart   = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_chunk_en  = 1'b0;
    w_cmd       = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ARM;
          w_cnt_nxt   = C_SETTLE_M1;
          w_restart   = 1'b1;
        end
      end
      S_ARM: begin
        w_busy = 1'b1;
        w_cmd  = CMD_LOAD;
        if (w_settled) begin
          w_state_nxt = S_SEND;
          w_cnt_nxt   = C_SETTLE;
          w_k_nxt     = 4'd1;
          w_restart   = 1'b1;
        end
      end
      S_SEND: begin
        w_busy     = 1'b1;
        w_cmd      = CMD_LOAD;
        w_chunk_en = 1'b1;
        if (w_settled) begin
          // ack is checked before timeout so a same-cycle ack still wins
          if (w_ack) begin
            w_cnt_nxt = C_SETTLE;
            w_restart = 1'b1;
            if (r_k == 4'd14) begin
              w_state_nxt = S_PROC;
            end else begin
              w_k_nxt = r_k + 4'd1;
            end
          end else if (w_tmo_hit) begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_PROC: begin
        w_busy = 1'b1;
        w_cmd  = CMD_PROC;
        if (w_settled) begin
          w_state_nxt = S_READ;
          w_cnt_nxt   = C_SETTLE;
          w_i_nxt     = 2'd0;
          w_restart   = 1'b1;
        end
      end
      S_READ: begin
        w_busy = 1'b1;
        w_cmd  = {4'h0, r_i, 10'h000};
        if (w_settled) begin
          if (w_valid) begin
            w_capture = 1'b1;
            w_cnt_nxt = C_SETTLE;
            w_restart = 1'b1;
            if (r_i == 2'd3) begin
              w_state_nxt = S_DONE;
            end else begin
              w_i_nxt = r_i + 2'd1;
            end
          end else if (w_tmo_hit) begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_k   <= 4'd1;
      r_i   <= 2'd0;
      for (int n = 0; n < 4; n++) begin
        r_res[n] <= '0;
      end
    end else begin
      r_cnt <= w_cnt_nxt;
      r_k   <= w_k_nxt;
      r_i   <= w_i_nxt;
      if (w_capture) begin
        r_res[r_i] <= la_in[113:32];
      end
    end
  end

  // Operand store has no reset; the host always loads it before a start.
  always_ff @(posedge clk) begin
    if (op_we && !w_busy) begin
      for (int n = 0; n < 7; n++) begin
        if (op_sel == 3'(n)) begin
          r_ops[n] <= op_wdata;
        end
      end
    end
  end

  // Chunk k carries operand (k-1)/2; odd k is the upper half, even k the lower.
  assign w_op_idx = 3'((r_k - 4'd1) >> 1);

  always_comb begin
    w_op = '0;
    for (int n = 0; n < 7; n++) begin
      if (w_op_idx == 3'(n)) begin
        w_op = r_ops[n];
      end
    end
  end

  assign w_tag     = 14'((15'd1 << r_k) - 15'd1);
  assign w_payload = r_k[0] ? {1'b0, w_op[162:82]} : w_op[81:0];

  // The payload field spans the command field. While a chunk is on the bus,
  // the payload owns those bits, and the loader identifies the word by its
  // non-zero tag.
  always_comb begin
    w_la         = '0;
    w_la[31:16]  = w_cmd;
    if (w_chunk_en) begin
      w_la[95:82] = w_tag;
      w_la[81:0]  = w_payload;
    end
  end

  assign la_out      = w_la;
  assign la_oenb_out = w_busy ? {112'h0, 16'hFFFF} : {128{1'b1}};
  assign busy        = w_busy;
  assign done        = w_done;
  assign rd_data     = r_res[rd_idx];

`ifdef BEC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] C_TMO_M1 = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_tmo;
  logic          r_error;
  logic [3:0]    r_err_chunk;
  logic          w_waiting;
  logic          w_unused;

  // Counts only sampled cycles of a wait; reloaded whenever a new wait starts.
  assign w_waiting = w_settled && ((r_state == S_SEND) || (r_state == S_READ));
  assign w_tmo_hit = (r_tmo == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo       <= C_TMO_M1;
      r_error     <= 1'b0;
      r_err_chunk <= 4'h0;
    end else begin
      if (w_restart) begin
        r_tmo <= C_TMO_M1;
      end else if (w_waiting && (r_tmo != '0)) begin
        r_tmo <= r_tmo - 1'b1;
      end
      if ((r_state == S_IDLE) && start) begin
        r_error     <= 1'b0;
        r_err_chunk <= 4'h0;
      end else if (w_state_nxt == S_ERR) begin
        r_error     <= 1'b1;
        r_err_chunk <= w_err_chunk_nxt;
      end
    end
  end

  assign error     = r_error;
  assign err_chunk = r_err_chunk;
  assign w_unused  = ^{la_in[125:114], la_in[31:0]};
`else
  logic w_unused;

  assign w_tmo_hit = 1'b0;
  assign error     = 1'b0;
  assign err_chunk = 4'h0;
  assign w_unused  = ^{la_in[125:114], la_in[31:0], w_restart, w_err_chunk_nxt,
                       (TIMEOUT > 0)};
`endif

endmodule

// File: tb/tb_bec_la_host_sequencer.sv
module tb_bec_la_host_sequencer;

  localparam int SETTLE = 2;
`ifdef BEC_SEQ_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`else
  localparam int TIMEOUT = 1024;
`endif

  logic         clk;
  logic         rst;
  logic         op_we;
  logic [2:0]   op_sel;
  logic [162:0] op_wdata;
  logic         start;
  logic         busy;
  logic         done;
  logic         error;
  logic [3:0]   err_chunk;
  logic [1:0]   rd_idx;
  logic [81:0]  rd_data;
  logic [127:0] la_out;
  logic [127:0] la_oenb_out;
  logic [127:0] la_in;

  bec_la_host_sequencer #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op_we(op_we), .op_sel(op_sel), .op_wdata(op_wdata),
    .start(start), .busy(busy), .done(done), .error(error), .err_chunk(err_chunk),
    .rd_idx(rd_idx), .rd_data(rd_data), .la_out(la_out),
    .la_oenb_out(la_oenb_out), .la_in(la_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model state and responder controls
  logic [162:0] m_ops [7];
  logic [81:0]  res_w [4];
  logic [81:0]  seen_pay [16];
  int hold_k = 0;
  int hold_n = 0;
  int nack_k = 0;

  // Monitor results
  int last_k, proc_len, n_done, hold_len, chunk3_len;
  bit seq_ok, payl_ok, busy_ok, hold_ok, err_seen, timed_out;
  logic [127:0] hold_word;

  localparam logic [81:0] R0 = 82'h3_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [81:0] R1 = 82'h0;
  localparam logic [81:0] R2 = 82'h1_5555_5555_5555_5555_5555;
  localparam logic [81:0] R3 = 82'h2_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam logic [127:0] W_ALL1 = {128{1'b1}};
  localparam logic [127:0] W_OENB_BUSY = {112'h0, 16'hFFFF};

  // Loader responder: acks chunks by tag count, answers read selectors.
  logic [127:0] rsp;
  int rk;
  int hold_seen = 0;
  always @(negedge clk) begin
    rsp = '0;
    rk = $countones(la_out[95:82]);
    if (rk != 0) begin
      if (rk == hold_k && hold_seen < hold_n) begin
        hold_seen <= hold_seen + 1;
      end else if (rk != nack_k) begin
        rsp[95:90] = 6'(16 + rk);
      end
      if (rk != hold_k) hold_seen <= 0;
    end else if (la_oenb_out[127] == 1'b0 && la_out[31:28] == 4'h0 &&
                 la_out[25:16] == 10'h0) begin
      rsp = {2'b11, 12'h000, res_w[la_out[27:26]], 32'h0};
    end
    la_in <= rsp;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [81:0] exp_payload(input int k);
    logic [162:0] op;
    op = m_ops[(k - 1) / 2];
    if (k % 2 == 1) return {1'b0, op[162:82]};
    return op[81:0];
  endfunction

  task automatic write_op(input int sel, input logic [162:0] d);
    @(negedge clk);
    op_we = 1'b1;
    op_sel = 3'(sel);
    op_wdata = d;
    @(negedge clk);
    op_we = 1'b0;
  endtask

  task automatic load_model();
    for (int n = 0; n < 7; n++) write_op(n, m_ops[n]);
  endtask

  task automatic start_txn(input bit inject, input logic [162:0] inj_val);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 256'(busy), 256'(1'b1));
    check("oenb_busy", 256'(la_oenb_out), 256'(W_OENB_BUSY));
    check("arm_word", 256'(la_out), 256'({96'h0, 16'hAB40, 16'h0}));
    check("error_cleared", 256'(error), 256'(1'b0));
    if (inject) begin
      op_we = 1'b1;
      op_sel = 3'd0;
      op_wdata = inj_val;
      start = 1'b1;
      @(negedge clk);
      op_we = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic run_txn(input int budget);
    int k;
    int post;
    logic [127:0] w;
    last_k = 0; proc_len = 0; n_done = 0; hold_len = 0; chunk3_len = 0;
    seq_ok = 1; payl_ok = 1; busy_ok = 1; hold_ok = 1; err_seen = 0; timed_out = 1;
    post = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      w = la_out;
      k = $countones(w[95:82]);
      if (k != 0) begin
        if (w[95:82] != 14'((15'd1 << k) - 15'd1)) seq_ok = 0;
        if (k != last_k) begin
          if (k != last_k + 1) seq_ok = 0;
          seen_pay[k] = w[81:0];
          if (w[81:0] !== exp_payload(k) || w[127:96] != 32'h0) payl_ok = 0;
          hold_word = w;
          last_k = k;
        end
        if (k == hold_k) begin
          hold_len++;
          if (w !== hold_word) hold_ok = 0;
        end
        if (k == 3) chunk3_len++;
      end else if (w == {96'h0, 16'hAB41, 16'h0}) begin
        proc_len++;
      end
      if (done) begin
        n_done++;
        if (busy) busy_ok = 0;
      end
      if (error) err_seen = 1;
      if (post < 0 && (done || error)) begin
        post = 0;
      end else if (post >= 0) begin
        post++;
        if (post == 5) begin
          timed_out = 0;
          break;
        end
      end
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1; op_we = 1'b0; op_sel = 3'd0; op_wdata = '0; start = 1'b0; rd_idx = 2'd0;
    res_w[0] = R0; res_w[1] = R1; res_w[2] = R2; res_w[3] = R3;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_la_out", 256'(la_out), 256'(128'h0));
    check("rst_oenb", 256'(la_oenb_out), 256'(W_ALL1));
    check("rst_busy", 256'(busy), 256'(1'b0));
    check("rst_done", 256'(done), 256'(1'b0));
    check("rst_error", 256'(error), 256'(1'b0));
    check("rst_err_chunk", 256'(err_chunk), 256'(4'h0));
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      check("rst_res", 256'(rd_data), 256'(82'h0));
    end
    rst = 1'b0;

    // Transaction 1: a = 1, rest zero
    for (int n = 0; n < 7; n++) m_ops[n] = '0;
    m_ops[0] = 163'h1;
    load_model();
    start_txn(1'b0, '0);
    run_txn(500);
    check("t1_finished", 256'(timed_out), 256'(1'b0));
    check("t1_chunk1_payload", 256'(seen_pay[1]), 256'(82'h0));
    check("t1_chunk2_payload", 256'(seen_pay[2]), 256'(82'h1));
    check("t1_last_chunk", 256'(last_k), 256'(14));
    check("t1_sequence", 256'(seq_ok), 256'(1'b1));
    check("t1_payloads", 256'(payl_ok), 256'(1'b1));
    check("t1_proc_len", 256'(proc_len), 256'(SETTLE + 1));
    check("t1_done_count", 256'(n_done), 256'(1));
    check("t1_busy_with_done", 256'(busy_ok), 256'(1'b1));
    check("t1_idle_la_out", 256'(la_out), 256'(128'h0));
    check("t1_idle_oenb", 256'(la_oenb_out), 256'(W_ALL1));
    rd_idx = 2'd0; #1; check("t1_rd0", 256'(rd_data), 256'(R0));
    rd_idx = 2'd1; #1; check("t1_rd1", 256'(rd_data), 256'(R1));
    rd_idx = 2'd2; #1; check("t1_rd2", 256'(rd_data), 256'(R2));
    rd_idx = 2'd3; #1; check("t1_rd3", 256'(rd_data), 256'(R3));

    // Transaction 2: distinct operands, chunk 5 ack delayed 50 cycles
    for (int n = 0; n < 7; n++)
      m_ops[n] = {3'(n), 32'hA5A5_0000 + 32'(n), 64'h0123_4567_89AB_CDEF,
                  64'(n + 1) * 64'h1111_1111};
    load_model();
    res_w[0] = R1; res_w[1] = R2; res_w[2] = R3; res_w[3] = R0;
    hold_k = 5; hold_n = 50;
    start_txn(1'b0, '0);
    run_txn(800);
    hold_k = 0; hold_n = 0;
    check("t2_finished", 256'(timed_out), 256'(1'b0));
    check("t2_sequence", 256'(seq_ok), 256'(1'b1));
    check("t2_payloads", 256'(payl_ok), 256'(1'b1));
    check("t2_last_chunk", 256'(last_k), 256'(14));
    check("t2_hold_stable", 256'(hold_ok), 256'(1'b1));
    check("t2_hold_len", 256'(hold_len), 256'(51));
    check("t2_done_count", 256'(n_done), 256'(1));
    rd_idx = 2'd0; #1; check("t2_rd0", 256'(rd_data), 256'(R1));
    rd_idx = 2'd3; #1; check("t2_rd3", 256'(rd_data), 256'(R0));

    // Transaction 3: op_we and start while busy are ignored
    start_txn(1'b1, {163{1'b1}});
    run_txn(500);
    check("t3_finished", 256'(timed_out), 256'(1'b0));
    check("t3_chunk1_unchanged", 256'(seen_pay[1]), 256'({1'b0, m_ops[0][162:82]}));
    check("t3_chunk2_unchanged", 256'(seen_pay[2]), 256'(m_ops[0][81:0]));
    check("t3_payloads", 256'(payl_ok), 256'(1'b1));
    check("t3_done_count", 256'(n_done), 256'(1));
    check("t3_no_restart", 256'(busy), 256'(1'b0));

    // Transaction 4: reset while reading result 2
    res_w[0] = R0; res_w[1] = R3; res_w[2] = R2; res_w[3] = R1;
    start_txn(1'b0, '0);
    found = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (busy && la_out == {96'h0, 16'h0800, 16'h0}) begin
        found = 1;
        break;
      end
    end
    check("t4_reached_read2", 256'(found), 256'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_la_out", 256'(la_out), 256'(128'h0));
    check("t4_rst_oenb", 256'(la_oenb_out), 256'(W_ALL1));
    check("t4_rst_busy", 256'(busy), 256'(1'b0));
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      check("t4_res_cleared", 256'(rd_data), 256'(82'h0));
    end
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("t4_no_done", 256'(n_done), 256'(0));
    check("t4_stays_idle", 256'(busy), 256'(1'b0));

`ifdef BEC_SEQ_TIMEOUT_EN
    // Transaction 5: chunk 3 never acked
    load_model();
    nack_k = 3;
    start_txn(1'b0, '0);
    run_txn(500);
    nack_k = 0;
    check("t5_finished", 256'(timed_out), 256'(1'b0));
    check("t5_err_seen", 256'(err_seen), 256'(1'b1));
    check("t5_chunk3_len", 256'(chunk3_len), 256'(SETTLE + TIMEOUT));
    check("t5_error", 256'(error), 256'(1'b1));
    check("t5_err_chunk", 256'(err_chunk), 256'(4'h3));
    check("t5_la_out", 256'(la_out), 256'(128'h0));
    check("t5_busy", 256'(busy), 256'(1'b0));
    check("t5_no_done", 256'(n_done), 256'(0));
    start_txn(1'b0, '0);
    run_txn(500);
    check("t5_recover_done", 256'(n_done), 256'(1));
    check("t5_recover_error", 256'(error), 256'(1'b0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
